// File: rtl/tmds_pll_supervisor.sv
// Reset sequencer and lock supervisor for Gowin rPLL instances: pulses PLL RESET, waits
// for lock, requires a stable lock interval, then releases the video domain reset.
//   state        | meaning
//   ST_RESET_PLL | pll_reset high for PLL_RESET_CYCLES
//   ST_WAIT_LOCK | waiting for all PLLs to lock, bounded by LOCK_TIMEOUT_CYCLES
//   ST_STABILIZE | lock must hold for LOCK_STABLE_CYCLES
//   ST_RUN       | video domain released; any lock loss re-arms
module tmds_pll_supervisor #(
  parameter int NUM_PLLS            = 1,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PLLS-1:0] pll_lock,
  input  logic                force_relock,
  output logic [NUM_PLLS-1:0] pll_reset,
  output logic                sys_rst_n,
  output logic                ready,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    retry_count,
  output logic [CNT_W-1:0]    loss_count
);

  localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC);

  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_RESET_PLL = 4'b0001,
    ST_WAIT_LOCK = 4'b0010,
    ST_STABILIZE = 4'b0100,
    ST_RUN       = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  logic [NUM_PLLS-1:0] sync_meta_q, sync_meta_d;
  logic [NUM_PLLS-1:0] sync_q, sync_d;
  logic [NUM_PLLS-1:0] pll_reset_q, pll_reset_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                all_locked;

  assign all_locked = &sync_q;

  always_comb begin
    sync_meta_d = pll_lock;
    sync_d      = sync_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    loss_d      = loss_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock beats a timeout landing on the same cycle, so no retry is counted.
        if (all_locked) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (force_relock) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_STABILIZE: begin
        if (force_relock) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end else if (!all_locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_RUN: begin
        // A loss coinciding with force_relock is still recorded as a loss.
        if (!all_locked) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else if (force_relock) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = {NUM_PLLS{state_d == ST_RESET_PLL}};
    sys_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync_meta_q <= '0;
      sync_q      <= '0;
      pll_reset_q <= '1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_RESET_PLL: state = 2'd0;
      ST_WAIT_LOCK: state = 2'd1;
      ST_STABILIZE: state = 2'd2;
      ST_RUN:       state = 2'd3;
      default:      state = 2'd0;
    endcase
  end

  assign pll_reset   = pll_reset_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = sys_rst_n_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Directed bench for tmds_pll_supervisor: a cycle table for nominal bring-up, then
// hand-written sequences for timeouts, chatter, loss saturation and force_relock.
module tb_tmds_pll_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pll_lock;
  logic       force_relock;
  logic [1:0] pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [3:0] retry_count;
  logic [3:0] loss_count;

  int n_vec = 0;
  int n_err = 0;

  tmds_pll_supervisor #(
    .NUM_PLLS(2), .PLL_RESET_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .force_relock(force_relock),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .ready(ready), .state(state),
    .retry_count(retry_count), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] lock;
    logic       frc;
    logic [1:0] exp_pll_reset;
    logic       exp_sys;
    logic [1:0] exp_state;
    logic [3:0] exp_retry;
    logic [3:0] exp_loss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic [1:0] l, input logic f,
                     input logic [1:0] pr, input logic s, input logic [1:0] st,
                     input logic [3:0] rc, input logic [3:0] lc);
    vec_t v;
    v.rst_n = r; v.lock = l; v.frc = f; v.exp_pll_reset = pr; v.exp_sys = s;
    v.exp_state = st; v.exp_retry = rc; v.exp_loss = lc;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    int n = 0;
    while (state !== s && n < max) begin
      step();
      n++;
    end
    chk(name, state, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   pulses, high;
    logic prev, sys_seen;
    logic [3:0] exp_loss;

    rst_n = 1'b0; pll_lock = 2'b00; force_relock = 1'b0;

    // Nominal bring-up: locks rise 10 cycles after pll_reset falls.
    add(2,  1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 2'd0, 4'd0, 4'd0);
    add(3,  1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'd0, 4'd0, 4'd0);
    add(10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd1, 4'd0, 4'd0);
    add(2,  1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd1, 4'd0, 4'd0);
    add(8,  1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd2, 4'd0, 4'd0);
    add(3,  1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 2'd3, 4'd0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; pll_lock = vecs[i].lock; force_relock = vecs[i].frc;
      step();
      chk($sformatf("vec%0d pll_reset", i), pll_reset, vecs[i].exp_pll_reset);
      chk($sformatf("vec%0d sys_rst_n", i), sys_rst_n, vecs[i].exp_sys);
      chk($sformatf("vec%0d ready", i), ready, vecs[i].exp_sys);
      chk($sformatf("vec%0d state", i), state, vecs[i].exp_state);
      chk($sformatf("vec%0d retry", i), retry_count, vecs[i].exp_retry);
      chk($sformatf("vec%0d loss", i), loss_count, vecs[i].exp_loss);
    end

    // Timeout retries with only one PLL locking.
    pll_lock = 2'b01;
    do_reset();
    pulses = 1; high = 0; prev = pll_reset[0]; sys_seen = 1'b0;
    for (int e = 1; e <= 108; e++) begin
      step();
      if (pll_reset[0] && !prev) pulses++;
      if (pll_reset[0]) high++;
      prev = pll_reset[0];
      if (sys_rst_n) sys_seen = 1'b1;
    end
    chk("timeout pulses", pulses, 4);
    chk("timeout high cycles", high, 12);
    chk("timeout retry_count", retry_count, 3);
    chk("timeout sys_rst_n stayed low", sys_seen, 0);
    chk("timeout state", state, 0);
    chk("timeout pll_reset bits", pll_reset, 2'b11);

    // Loss coinciding with force_relock in RUN, then reset while in RUN.
    pll_lock = 2'b11;
    wait_state(2'd3, 60, "simul reach RUN");
    chk("simul retry kept", retry_count, 3);
    pll_lock = 2'b00;
    step();
    step();
    chk("simul still RUN", state, 3);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("simul state", state, 0);
    chk("simul loss_count", loss_count, 1);
    chk("simul sys_rst_n", sys_rst_n, 0);
    pll_lock = 2'b11;
    wait_state(2'd3, 60, "rst reach RUN");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst state", state, 0);
    chk("midrst pll_reset", pll_reset, 2'b11);
    chk("midrst sys_rst_n", sys_rst_n, 0);
    chk("midrst ready", ready, 0);
    chk("midrst retry", retry_count, 0);
    chk("midrst loss", loss_count, 0);

    // Lock chatter during STABILIZE.
    pll_lock = 2'b11;
    do_reset();
    wait_state(2'd2, 20, "chatter reach STABILIZE");
    repeat (5) step();
    pll_lock = 2'b01;
    step();
    step();
    chk("chatter still STABILIZE", state, 2);
    step();
    chk("chatter back to WAIT", state, 1);
    pll_lock = 2'b11;
    repeat (10) step();
    chk("chatter k+9 state", state, 2);
    chk("chatter k+9 sys", sys_rst_n, 0);
    step();
    chk("chatter RUN state", state, 3);
    chk("chatter RUN sys", sys_rst_n, 1);
    chk("chatter retry", retry_count, 0);
    chk("chatter loss", loss_count, 0);

    // Repeated loss in RUN, loss_count saturates at 15.
    for (int i = 0; i < 20; i++) begin
      exp_loss = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      pll_lock = 2'b00;
      step();
      step();
      chk($sformatf("loss%0d k+1 sys", i), sys_rst_n, 1);
      step();
      chk($sformatf("loss%0d state", i), state, 0);
      chk($sformatf("loss%0d sys", i), sys_rst_n, 0);
      chk($sformatf("loss%0d count", i), loss_count, exp_loss);
      pll_lock = 2'b11;
      repeat (3) step();
      chk($sformatf("loss%0d pll_reset last", i), pll_reset, 2'b11);
      step();
      chk($sformatf("loss%0d pll_reset end", i), pll_reset, 2'b00);
      wait_state(2'd3, 40, $sformatf("loss%0d back to RUN", i));
    end

    // force_relock in RUN, WAIT_LOCK and RESET_PLL.
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force RUN state", state, 0);
    chk("force RUN sys", sys_rst_n, 0);
    chk("force RUN loss", loss_count, 15);
    chk("force RUN retry", retry_count, 0);
    pll_lock = 2'b00;
    wait_state(2'd1, 10, "force reach WAIT");
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force WAIT state", state, 0);
    chk("force WAIT retry", retry_count, 0);
    chk("force WAIT loss", loss_count, 15);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force RESET state", state, 0);
    step();
    step();
    chk("force RESET width last", pll_reset, 2'b11);
    step();
    chk("force RESET width end", pll_reset, 2'b00);
    chk("force RESET to WAIT", state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_pll_supervisor.md
# tmds_pll_supervisor

Reset sequencer and lock supervisor for one or more Gowin rPLL instances, such as the TMDS serial/pixel clock PLL. It runs on the free-running board reference clock and drives each PLL's RESET input. It holds the downstream video logic in reset until every supervised PLL has held lock continuously for a programmable interval. It re-arms the PLLs automatically when lock does not arrive in time, when lock is lost during operation, or on request, and it counts each of those events for debug.

## Interface
Parameters:
- NUM_PLLS, 1 — number of supervised PLLs; all must be locked for the block to count as locked.
- PLL_RESET_CYCLES, 16 — cycles for which pll_reset is held high per reset attempt (≥2).
- LOCK_TIMEOUT_CYCLES, 65536 — maximum cycles spent waiting for lock before re-arming (≥2).
- LOCK_STABLE_CYCLES, 1024 — cycles of continuous lock required before release (≥2).
- CNT_W, 8 — width of the event counters.

Ports:
- clk  in  1  reference clock, e.g. 27 MHz crystal; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- pll_lock  in  NUM_PLLS  raw PLL LOCK outputs; asynchronous to clk.
- force_relock  in  1  single-cycle request to restart the sequence.
- pll_reset  out  NUM_PLLS  active-high PLL reset; all bits are identical.
- sys_rst_n  out  1  active-low reset for the video domain; low until lock is stable.
- ready  out  1  high when in RUN; equals sys_rst_n.
- state  out  2  current state: 0=RESET_PLL, 1=WAIT_LOCK, 2=STABILIZE, 3=RUN.
- retry_count  out  CNT_W  number of lock timeouts; saturates at all-ones.
- loss_count  out  CNT_W  number of lock losses while in RUN; saturates.

## Operation
- Each bit of pll_lock passes through a 2-flop synchronizer. all_locked is the AND of the synchronized bits.
- Internally the FSM uses one-hot state plus a single cycle counter cnt, sized $clog2 of the largest parameter. pll_reset and sys_rst_n are driven directly from flops, never from combinational decode.
- RESET_PLL: pll_reset=1. cnt increments each cycle. When cnt==PLL_RESET_CYCLES-1, go to WAIT_LOCK and clear cnt.
- WAIT_LOCK: pll_reset=0. Transitions in priority order:
  - all_locked → STABILIZE, cnt=0.
  - else force_relock → RESET_PLL.
  - else cnt==LOCK_TIMEOUT_CYCLES-1 → RESET_PLL and retry_count+1.
  - otherwise cnt+1.
- STABILIZE: transitions in priority order:
  - force_relock → RESET_PLL.
  - !all_locked → WAIT_LOCK, cnt=0; no counter increment.
  - cnt==LOCK_STABLE_CYCLES-1 → RUN.
  - otherwise cnt+1.
- RUN: sys_rst_n=1, ready=1.
  - !all_locked → RESET_PLL and loss_count+1. This applies even when force_relock is asserted in the same cycle; the loss is still counted.
  - force_relock alone → RESET_PLL with no count.
- Every entry to RESET_PLL clears cnt.
- force_relock is ignored while already in RESET_PLL.
- sys_rst_n drops in the same cycle that state leaves RUN.
- Both counters saturate; neither wraps.
- A lock glitch shorter than one clk period may be missed by the synchronizer. This is acceptable.

## Timing
- While rst_n=0 at an edge, the following values are loaded: state=RESET_PLL, cnt=0, pll_reset=all ones, sys_rst_n=0, ready=0, both counters=0, synchronizers=0.
- Reset asserted mid-operation takes effect at the next edge. It restarts the full sequence and clears both counters.
- pll_reset is high for exactly PLL_RESET_CYCLES cycles per attempt, including the attempt that follows reset release.
- Lock-in latency: pll_lock goes all-high and is first captured at edge k. all_locked is high after edge k+1. state=STABILIZE after edge k+2. state=RUN and sys_rst_n=1 after edge k+2+LOCK_STABLE_CYCLES.
- Lock-loss latency: a drop captured at edge k gives state=RESET_PLL and sys_rst_n=0 after edge k+2.
- force_relock sampled at edge k gives state=RESET_PLL after edge k. No synchronizer delay applies.
- Simultaneous all_locked and timeout in WAIT_LOCK: lock wins, and retry_count is not incremented.

## Test plan
Use NUM_PLLS=2, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, CNT_W=4.

- Nominal bring-up: release rst_n and raise both locks 10 cycles after pll_reset falls → pll_reset=11 for exactly 4 cycles; sys_rst_n rises exactly 2+8 cycles after lock is captured; retry_count=0, loss_count=0.
- Timeout retries: keep pll_lock=01 for 3×(4+32) cycles → pll_reset pulses 4 times in total; retry_count=3; sys_rst_n stays 0 throughout.
- Lock chatter during STABILIZE: drop bit 1 for 3 cycles after 5 stable cycles → state returns to WAIT_LOCK and counters are unchanged; RUN is reached 2+8 cycles after lock returns.
- Loss in RUN plus saturation: from RUN, drop lock 20 times → sys_rst_n falls 2 cycles after each drop and a 4-cycle pll_reset follows each one; loss_count saturates at 15.
- force_relock: pulse it in RUN, in WAIT_LOCK and in RESET_PLL → RESET_PLL is entered on the next edge in the first two cases, with no counter change; the pulse in RESET_PLL changes nothing and pll_reset width stays 4.
- Simultaneous and reset cases: drop lock in the same cycle as force_relock in RUN → loss_count+1. Assert rst_n=0 for 1 cycle while in RUN → all outputs return to their reset values on the next edge.
